// File: rtl/norm_scale_unit_pkg.sv
// norm_scale_unit_pkg
// Shared defaults for the normalization path (data width, LUT fraction,
// sum-of-squares shift) and the normalization LUT contents used by the ROM.
// The table holds unsigned scale factors with NORM_LUT_FRAC fractional bits
// (0x8000 = 1.0).
package norm_scale_unit_pkg;

  localparam int NORM_DATA_WIDTH = 16;
  localparam int NORM_LUT_FRAC   = 15;
  localparam int NORM_SUM_SHIFT  = 10;

  typedef logic [NORM_DATA_WIDTH-1:0] lut_word_t;

  // LUT contents: anchor points at 0 (unity), 5 (one half) and 63 (just
  // under 2.0); the remaining entries fall off linearly from unity.
  function automatic lut_word_t lut_word(input int unsigned idx);
    lut_word_t w;
    case (idx)
      0:       w = 16'h8000;
      5:       w = 16'h4000;
      63:      w = 16'hFFFF;
      default: w = 16'h8000 - 16'(idx << 8);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/norm_round_sat.sv
// norm_round_sat
// Combinational round-half-up (add half an LSB, arithmetic shift) followed
// by saturation to a signed OUT_WIDTH result.
// Ports:
//   din   signed fixed-point value with FRAC fractional bits
//   dout  rounded, saturated signed integer
module norm_round_sat #(
  parameter int IN_WIDTH  = 33,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC      = 15
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int SW = IN_WIDTH + 1;
  localparam logic signed [SW-1:0] HALF  = SW'(1) <<< (FRAC - 1);
  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    sum     = {din[IN_WIDTH-1], din} + HALF;
    shifted = sum >>> FRAC;
    if (shifted > MAX_V)      dout = MAX_V[OUT_WIDTH-1:0];
    else if (shifted < MIN_V) dout = MIN_V[OUT_WIDTH-1:0];
    else                      dout = shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/norm_scale_unit_rom.sv
// norm_scale_unit_rom
// Normalization LUT ROM with a one-cycle registered read.
// Ports:
//   clk, reset     clock; synchronous clear of the read register
//   en             read enable; data_out holds while en=0
//   addr           LUT address
//   data_out       LUT word, valid the cycle after an enabled read
module norm_scale_unit_rom
  import norm_scale_unit_pkg::*;
#(
  parameter int    ADDR_WIDTH = 6,
  parameter int    DATA_WIDTH = NORM_DATA_WIDTH,
  parameter string TYPE       = "DISTRIBUTED"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
    assign mem[gi] = DATA_WIDTH'(lut_word(gi));
  end

  generate
    if (TYPE == "BLOCK") begin : g_block
      // Block style: register the address, read the array behind it.
      logic [ADDR_WIDTH-1:0] addr_q;
      always_ff @(posedge clk) begin
        if (reset)   addr_q <= '0;
        else if (en) addr_q <= addr;
      end
      assign data_out = mem[addr_q];
    end else begin : g_dist
      // Distributed style: register the read data.
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk) begin
        if (reset)   data_q <= '0;
        else if (en) data_q <= mem[addr];
      end
      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: rtl/norm_scale_unit.sv
// norm_scale_unit
// Scales activation x by a LUT factor selected from its sum of squares s:
// out = sat(round(x * lut[clamp(s >> SUM_SHIFT)] / 2^LUT_FRAC)).
// Three-stage pipeline (ROM read, multiply, round/saturate) that moves as a
// whole whenever the output register can be emptied.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_data = x (signed),
//                         in_sumsq = s (unsigned)
//   out_valid/out_ready   output handshake; out_data = scaled result (signed)
module norm_scale_unit
  import norm_scale_unit_pkg::*;
#(
  parameter int    DATA_WIDTH = NORM_DATA_WIDTH,
  parameter int    ADDR_WIDTH = 6,
  parameter int    SUM_WIDTH  = 32,
  parameter int    SUM_SHIFT  = NORM_SUM_SHIFT,
  parameter int    LUT_FRAC   = NORM_LUT_FRAC,
  parameter string ROM_TYPE   = "DISTRIBUTED"
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic        [SUM_WIDTH-1:0]  in_sumsq,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam int ROM_DEPTH = 1 << ADDR_WIDTH;
  localparam int P_W       = 2 * DATA_WIDTH + 1;
  // Smallest s whose shifted value no longer fits the address range.
  localparam logic [SUM_WIDTH-1:0] SAT_THRESH = SUM_WIDTH'(ROM_DEPTH) << SUM_SHIFT;

  logic                         advance;
  logic [ADDR_WIDTH-1:0]        rom_addr;
  logic [DATA_WIDTH-1:0]        lut;

  logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
  logic                         v1_q, v1_d;
  logic signed [P_W-1:0]        p2_q, p2_d;
  logic                         v2_q, v2_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] rs_out;
  logic signed [P_W-1:0]        x_ext, lut_ext;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Saturating address map; comparing the full s keeps the clamp exact.
  always_comb begin
    if (in_sumsq >= SAT_THRESH) rom_addr = ADDR_WIDTH'(ROM_DEPTH - 1);
    else                        rom_addr = in_sumsq[SUM_SHIFT +: ADDR_WIDTH];
  end

  // ROM read register is the stage-1 data register for the LUT word.
  norm_scale_unit_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TYPE       (ROM_TYPE)
  ) u_rom (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .addr     (rom_addr),
    .data_out (lut)
  );

  norm_round_sat #(
    .IN_WIDTH  (P_W),
    .OUT_WIDTH (DATA_WIDTH),
    .FRAC      (LUT_FRAC)
  ) u_round_sat (
    .din  (p2_q),
    .dout (rs_out)
  );

  always_comb begin
    // x sign-extended, LUT word zero-extended: signed x unsigned product.
    x_ext       = P_W'(x1_q);
    lut_ext     = signed'(P_W'(lut));
    x1_d        = x1_q;
    v1_d        = v1_q;
    p2_d        = p2_q;
    v2_d        = v2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      x1_d        = in_data;
      v1_d        = in_valid;
      p2_d        = x_ext * lut_ext;
      v2_d        = v1_q;
      out_data_d  = rs_out;
      out_valid_d = v2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q        <= '0;
      v1_q        <= 1'b0;
      p2_q        <= '0;
      v2_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x1_q        <= x1_d;
      v1_q        <= v1_d;
      p2_q        <= p2_d;
      v2_q        <= v2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_norm_scale_unit.sv
// tb_norm_scale_unit
// Scoreboard bench: expected results are queued when a beat is accepted and
// compared in order when the DUT hands a result downstream.
module tb_norm_scale_unit;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic        [31:0] in_sumsq;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic               stall_prev = 1'b0;
  logic signed [15:0] stall_data = '0;

  always #5 clk = ~clk;

  norm_scale_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sumsq  (in_sumsq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Test LUT: unity at 0, half at 5, 0xFFFF at 63, linear fall-off elsewhere.
  function automatic longint model_lut(input int a);
    if (a == 0)  return 32768;
    if (a == 5)  return 16384;
    if (a == 63) return 65535;
    return 32768 - 256 * a;
  endfunction

  function automatic int model(input int x, input longint unsigned s);
    longint unsigned t;
    int a;
    longint p, r;
    t = s / 1024;
    a = (t > 63) ? 63 : int'(t);
    p = longint'(x) * model_lut(a);
    r = (p + 16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // One clock of stimulus: drive after the edge, observe the handshake at the
  // negedge, and queue the expectation if the beat is taken.
  task automatic drive(input logic v, input int x, input logic [31:0] s,
                       input logic rdy, output logic acc);
    in_valid  = v;
    in_data   = 16'(x);
    in_sumsq  = s;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(model(x, s));
      $display("IN  x=%0d s=%0d exp=%0d", x, s, model(x, s));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Checks latency of one beat against 3 cycles, with no stall.
  task automatic latency_beat(input int x, input logic [31:0] s, input string tag);
    logic acc;
    drive(1'b1, x, s, 1'b1, acc);
    idle();
    check_eq({tag, "_acc"}, acc, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq({tag, "_valid_c", $sformatf("%0d", k)}, out_valid, (k == 3) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares every transferred result against the scoreboard
  // and checks that a stalled output stays put with in_ready low.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          $display("OUT data=%0d exp=%0d", out_data, e);
          check_eq("out_data", out_data, e);
        end
      end
      if (out_valid && !out_ready) begin
        check_eq("stall_in_ready", in_ready, 0);
        if (stall_prev) check_eq("stall_hold", out_data, stall_data);
        stall_prev = 1'b1;
        stall_data = out_data;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx;
    int   xs[8];
    logic [31:0] ss[8];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sumsq  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Unity scale at address 0, with 3-cycle latency.
    latency_beat(1000, 32'd0, "lat_s0");

    // Address 5 (half), round half up; address 4 just below it.
    drive(1'b1, -301, 32'd5120, 1'b1, acc);
    drive(1'b1, 1234, 32'd5119, 1'b1, acc);
    // Address clamp at the top; saturation both ways; x=0.
    drive(1'b1, 32767, 32'hFFFF_FFFF, 1'b1, acc);
    drive(1'b1, -32768, 32'hFFFF_FFFF, 1'b1, acc);
    drive(1'b1, 0, 32'hFFFF_FFFF, 1'b1, acc);
    drive(1'b1, 777, 32'd65536, 1'b1, acc);
    idle();
    wait_drain();

    // 8-beat stream with a 5-cycle downstream stall starting mid-stream.
    for (int i = 0; i < 8; i++) begin
      xs[i] = int'($urandom_range(0, 65535)) - 32768;
      ss[i] = $urandom_range(0, 80000);
    end
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      drive(1'b1, xs[idx], ss[idx], !(c >= 4 && c < 9), acc);
      if (acc) idx++;
    end
    idle();
    out_ready = 1'b1;
    check_eq("stream_sent", idx, 8);
    wait_drain();

    // Reset with 3 beats in flight: outputs clear at once, nothing stale.
    drive(1'b1, 100, 32'd0, 1'b1, acc);
    drive(1'b1, 200, 32'd0, 1'b1, acc);
    drive(1'b1, 300, 32'd0, 1'b1, acc);
    idle();
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    latency_beat(-5, 32'd3000, "lat_post_rst");
    wait_drain();

    // Alternating valid/bubble input at full downstream rate.
    for (int i = 0; i < 12; i++) begin
      drive(i % 2 == 0, int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 70000), 1'b1, acc);
    end
    idle();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
